// File: rtl/hazard_sched_unit_if.sv
// Hazard controller bus: Decode-stage register tags and status flags in,
// pipeline stall/flush/forward controls, FSM state and perf counters out.
//   master : pipeline side (drives Decode/Execute/Memory status, reads controls)
//   slave  : hazard_sched_unit
interface hazard_sched_unit_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] RdD;
  logic              ValidD;
  logic              RegWriteD;
  logic              LoadD;
  logic              PCSrcE;
  logic              DMemReadyM;
  logic              cnt_clr;

  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              StallM;
  logic              StallW;
  logic              FlushD;
  logic              FlushE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output Rs1D, Rs2D, RdD, ValidD, RegWriteD, LoadD, PCSrcE, DMemReadyM, cnt_clr,
    input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
    input  ForwardAE, ForwardBE, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, ValidD, RegWriteD, LoadD, PCSrcE, DMemReadyM, cnt_clr,
    output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
    output ForwardAE, ForwardBE, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sched_unit.sv
// Hazard controller for the 5-stage F/D/E/M/W core. Tracks register tags of
// the instructions in E, M and W, and derives forwarding selects, load-use
// stalls, branch-redirect flushes and memory-wait freezes. Saturating
// stall/flush performance counters are kept alongside.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - hazard_sched_unit_if.slave (Decode tags/status in, controls out)
module hazard_sched_unit #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_sched_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MEMWAIT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;

  logic              e_v, e_we, e_ld;
  logic [REG_AW-1:0] e_rs1, e_rs2, e_rd;
  logic              m_v, m_we;
  logic [REG_AW-1:0] m_rd;
  logic              w_v, w_we;
  logic [REG_AW-1:0] w_rd;

  logic [CNT_W-1:0]  stall_q, flush_q;

  logic memwait, redirect, lduse, bubble_e;
  logic stall_f, stall_d, stall_all, flush_d, flush_e;
  logic m_hit_a, w_hit_a, m_hit_b, w_hit_b;

  // Memory wait is suppressed while in reset so every stall reads 0 then.
  assign memwait  = rst & ~bus.DMemReadyM;
  assign redirect = bus.PCSrcE;
  assign lduse    = e_v & e_ld & (e_rd != '0) & bus.ValidD &
                    ((e_rd == bus.Rs1D) | (e_rd == bus.Rs2D));

  always_comb begin
    state_d   = RUN;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_all = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    bubble_e  = 1'b0;
    if (memwait) begin
      state_d   = MEMWAIT;
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_all = 1'b1;
    end else if (redirect) begin
      flush_d  = rst;
      flush_e  = 1'b1;
      bubble_e = 1'b1;
    end else if (lduse) begin
      state_d  = LDSTALL;
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      flush_e  = 1'b1;
      bubble_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Shadow scoreboard: frozen on memory wait; otherwise it advances, with E
  // taking either the Decode tags or an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_v <= 1'b0; e_we <= 1'b0; e_ld <= 1'b0;
      e_rs1 <= '0; e_rs2 <= '0; e_rd <= '0;
      m_v <= 1'b0; m_we <= 1'b0; m_rd <= '0;
      w_v <= 1'b0; w_we <= 1'b0; w_rd <= '0;
    end else if (!memwait) begin
      w_v <= m_v; w_we <= m_we; w_rd <= m_rd;
      m_v <= e_v; m_we <= e_we; m_rd <= e_rd;
      if (bubble_e) begin
        e_v <= 1'b0; e_we <= 1'b0; e_ld <= 1'b0;
        e_rs1 <= '0; e_rs2 <= '0; e_rd <= '0;
      end else begin
        e_v   <= bus.ValidD;
        e_we  <= bus.RegWriteD;
        e_ld  <= bus.LoadD;
        e_rs1 <= bus.Rs1D;
        e_rs2 <= bus.Rs2D;
        e_rd  <= bus.RdD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (bus.cnt_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((state_d != RUN) && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
      if (redirect && !memwait && (flush_q != '1)) flush_q <= flush_q + CNT_ONE;
    end
  end

  assign m_hit_a = m_v & m_we & (m_rd != '0) & (m_rd == e_rs1);
  assign w_hit_a = w_v & w_we & (w_rd != '0) & (w_rd == e_rs1);
  assign m_hit_b = m_v & m_we & (m_rd != '0) & (m_rd == e_rs2);
  assign w_hit_b = w_v & w_we & (w_rd != '0) & (w_rd == e_rs2);

  assign bus.ForwardAE = m_hit_a ? 2'b10 : (w_hit_a ? 2'b01 : 2'b00);
  assign bus.ForwardBE = m_hit_b ? 2'b10 : (w_hit_b ? 2'b01 : 2'b00);

  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_d;
  assign bus.StallE    = stall_all;
  assign bus.StallM    = stall_all;
  assign bus.StallW    = stall_all;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.state     = state_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule

// File: doc/hazard_sched_unit.md
Name: hazard_sched_unit

Overview:
Pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W). It keeps a shadow scoreboard of each in-flight instruction's register tags in E, M and W. From that it drives operand-forwarding selects into Execute, load-use stalls, branch-redirect flushes and whole-pipe freezes on data-memory wait. It also keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of perf counters stall_cnt/flush_cnt
REG_AW, 5, register-index width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
Rs1D  input  REG_AW  rs1 field of instruction in Decode (InstrD[19:15])
Rs2D  input  REG_AW  rs2 field in Decode (InstrD[24:20])
RdD  input  REG_AW  rd field in Decode (InstrD[11:7])
ValidD  input  1  Decode holds a real instruction
RegWriteD  input  1  Decode instruction writes rd
LoadD  input  1  Decode instruction is a load (ResultSrcD==1)
PCSrcE  input  1  branch taken/redirect resolved in Execute
DMemReadyM  input  1  data memory ready; 0 = wait
cnt_clr  input  1  synchronous clear of perf counters
StallF  output  1  hold PC
StallD  output  1  hold F/D register
StallE  output  1  hold D/E register
StallM  output  1  hold E/M register
StallW  output  1  hold M/W register
FlushD  output  1  bubble F/D register
FlushE  output  1  bubble D/E register
ForwardAE  output  2  SrcA select: 00 RD1E, 10 ALUResultM, 01 ResultW
ForwardBE  output  2  SrcB select, same encoding
state  output  2  FSM state: 00 RUN, 01 LDSTALL, 10 MEMWAIT
stall_cnt  output  CNT_W  cycles with any stall
flush_cnt  output  CNT_W  branch redirects taken

Behaviour:
- Shadow regs: E{v,rs1,rs2,rd,we,ld}, M{v,rd,we}, W{v,rd,we}. Reset (rst=0): all v=0, state=RUN, counters=0. Consequently Forward*=00, Stall*=0 and FlushD=0. FlushE=PCSrcE, because PCSrcE is an input; all outputs are valid combinationally during reset.
- Tag match: requires v=1, we=1 and rd!=0. x0 never forwards or stalls.
- ForwardAE is combinational, M has priority over W: 10 if M matches E.rs1; else 01 if W matches E.rs1; else 00. ForwardBE is the same using E.rs2.
- Hazard conditions, priority high to low:
  - memwait = !DMemReadyM.
  - redirect = PCSrcE.
  - lduse = E.v & E.ld & E.rd!=0 & ValidD & (E.rd==Rs1D | E.rd==Rs2D). Comparison is conservative; both fields are always checked.
- memwait: StallF/D/E/M/W=1, FlushD=FlushE=0. Shadow regs all hold. The register file may rewrite W's result repeatedly, which is idempotent. redirect and lduse are ignored this cycle and re-evaluated when ready returns.
- redirect (no memwait): FlushD=1, FlushE=1, no stalls. Shadow E<=bubble (v=0), M<=E, W<=M. flush_cnt+1.
- lduse (no memwait/redirect): StallF=StallD=1, FlushE=1. Shadow E<=bubble, M<=E, W<=M. Lasts exactly 1 cycle, because the load then sits in M and W-forwarding covers it the cycle after.
- Normal: shadow E<=D fields (v=ValidD), M<=E, W<=M; all stalls/flushes 0.
- FSM: state reflects the condition active in the current cycle. MEMWAIT while memwait. LDSTALL while lduse and no memwait/redirect. Otherwise RUN. state is registered: it shows the previous cycle's decision.
- stall_cnt increments on each cycle with memwait or lduse. Both counters saturate at all-ones, never wrap. cnt_clr=1 zeroes both and overrides increment that cycle.
- Reset mid-operation asynchronously invalidates all shadow entries and returns state to RUN. Counters clear.

Test Plan:
- Back-to-back RAW: add x5 (E) then sub x6,x5,x7 in D; next cycle ForwardAE=10; the cycle after, an instr reading x5 as rs2 gets ForwardBE=01; rd=x0 sequence gives 00.
- Load-use: lw x3 in E, D reads rs2=x3 -> StallF=StallD=FlushE=1 for exactly 1 cycle, state=01 next cycle, stall_cnt=1, then ForwardBE=01.
- Branch taken: PCSrcE=1 for 1 cycle with lduse also true -> FlushD=FlushE=1, StallF=0, flush_cnt=1, stall_cnt unchanged.
- Memory wait: DMemReadyM=0 for 3 cycles while PCSrcE=1 -> all Stall*=1, flushes 0, stall_cnt+=3; on ready, redirect taken, flush_cnt+1.
- Saturation/clear: force 2^CNT_W+5 stall cycles -> stall_cnt=FFFF; cnt_clr=1 -> 0 next cycle.
- Async reset asserted mid memwait -> state=00, Forward*=00, Stall*=0 immediately, counters 0.
